axi4_lite_slave_regs: RTL and testbench

AXI4-Lite responder exposing a bank of NUM_REGS 32-bit read/write control registers to a bus master. It is the slave-side counterpart of the team's AXI4-Lite bus-master block and sits between an interconnect (or a master directly) and user logic. User logic consumes the register contents as a flattened output vector and a one-cycle write-notify pulse. Write and read channels run as independent state machines.

---
 rtl/axi4_lite_slave_regs.sv | 212 +++++++++++++++++++++
 tb/tb_axi4_lite_slave_regs.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite responder exposing NUM_REGS 32-bit read/write control registers.
// The write and read channels run as independent two-state machines. Every AXI
// output comes straight from a flop. User logic sees the register bank as a
// flat vector, plus a one-cycle notify pulse for each accepted write.
module axi4_lite_slave_regs #(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_ADDR_WIDTH = 32,
  parameter int NUM_REGS         = 16
) (
  input  logic                          M_AXI_ACLK,
  input  logic                          RESETN,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                    S_AXI_AWPROT,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  input  logic [C_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  output logic [1:0]                    S_AXI_BRESP,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                    S_AXI_ARPROT,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  output logic [C_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY,
  output logic [32*NUM_REGS-1:0]        REGS_OUT,
  output logic                          WR_PULSE,
  output logic [7:0]                    WR_INDEX
);

  localparam int          STRB_W = C_AXI_DATA_WIDTH / 8;
  localparam int          IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic {WR_COLLECT, WR_RESP} wr_state_t;
  typedef enum logic {RD_IDLE,    RD_DATA} rd_state_t;

  // Register index is the word address; anything at or past NUM_REGS is an error.
  function automatic logic idx_in_range(input logic [7:0] idx);
    return {1'b0, idx} < 9'(NUM_REGS);
  endfunction

  logic [C_AXI_DATA_WIDTH-1:0] regs [NUM_REGS];

  wr_state_t             wr_state, wr_state_next;
  logic                  have_aw, have_w;
  logic [7:0]            aw_index_q;
  logic [C_AXI_DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]     wstrb_q;
  logic                  aw_hs, w_hs, wr_fire, wr_ok;
  logic [7:0]            wr_idx;
  logic [C_AXI_DATA_WIDTH-1:0] wr_data;
  logic [STRB_W-1:0]     wr_strb;

  rd_state_t             rd_state, rd_state_next;
  logic                  ar_hs, rd_ok;
  logic [7:0]            rd_idx;

  // Inputs the register map does not decode.
  logic unused_inputs;
  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                           S_AXI_AWADDR[C_AXI_ADDR_WIDTH-1:10], S_AXI_AWADDR[1:0],
                           S_AXI_ARADDR[C_AXI_ADDR_WIDTH-1:10], S_AXI_ARADDR[1:0]};

  // Write-side decode: pick held or live address/data, detect the completing edge.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    aw_hs   = S_AXI_AWVALID && S_AXI_AWREADY;
    w_hs    = S_AXI_WVALID  && S_AXI_WREADY;
    wr_idx  = have_aw ? aw_index_q : S_AXI_AWADDR[9:2];
    wr_data = have_w  ? wdata_q    : S_AXI_WDATA;
    wr_strb = have_w  ? wstrb_q    : S_AXI_WSTRB;
    wr_ok   = idx_in_range(wr_idx);
    wr_fire = (wr_state == WR_COLLECT) && (have_aw || aw_hs) && (have_w || w_hs);
  end

  // Write FSM next state.
  always_comb begin
    wr_state_next = wr_state;
    case (wr_state)
      WR_COLLECT: if (wr_fire)      wr_state_next = WR_RESP;
      WR_RESP:    if (S_AXI_BREADY) wr_state_next = WR_COLLECT;
    endcase
  end

  // Write FSM state register.
  always_ff @(posedge M_AXI_ACLK) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!RESETN) wr_state <= WR_COLLECT;
    else         wr_state <= wr_state_next;
  end

  // Write channel flops: capture AW/W, readies, response and notify pulse.
  always_ff @(posedge M_AXI_ACLK) begin
    if (!RESETN) begin
      have_aw       <= 1'b0;
      have_w        <= 1'b0;
      aw_index_q    <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BRESP   <= RESP_OKAY;
      WR_PULSE      <= 1'b0;
      WR_INDEX      <= '0;
    end else begin
      WR_PULSE <= 1'b0;
      case (wr_state)
        WR_COLLECT: begin
          if (aw_hs) begin
            have_aw    <= 1'b1;
            aw_index_q <= S_AXI_AWADDR[9:2];
          end
          if (w_hs) begin
            have_w  <= 1'b1;
            wdata_q <= S_AXI_WDATA;
            wstrb_q <= S_AXI_WSTRB;
          end
          if (wr_fire) begin
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BRESP   <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            WR_PULSE      <= wr_ok;
            if (wr_ok) WR_INDEX <= wr_idx;
          end else begin
            S_AXI_AWREADY <= !(have_aw || aw_hs);
            S_AXI_WREADY  <= !(have_w  || w_hs);
          end
        end
        WR_RESP: begin
          if (S_AXI_BREADY) begin
            have_aw       <= 1'b0;
            have_w        <= 1'b0;
            S_AXI_AWREADY <= 1'b1;
            S_AXI_WREADY  <= 1'b1;
          end
        end
      endcase
    end
  end

  assign S_AXI_BVALID = (wr_state == WR_RESP);

  // Register bank: byte-masked update on the completing write edge.
  always_ff @(posedge M_AXI_ACLK) begin
    if (!RESETN) begin
      // NOTE: the bank is cleared on reset because user logic relies on known control values.
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_fire && wr_ok) begin
      for (int b = 0; b < STRB_W; b++)
        if (wr_strb[b]) regs[wr_idx[IDX_W-1:0]][8*b +: 8] <= wr_data[8*b +: 8];
    end
  end

  // Read-side decode.
  always_comb begin
    ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
    rd_idx = S_AXI_ARADDR[9:2];
    rd_ok  = idx_in_range(rd_idx);
  end

  // Read FSM next state.
  always_comb begin
    rd_state_next = rd_state;
    case (rd_state)
      RD_IDLE: if (ar_hs)        rd_state_next = RD_DATA;
      RD_DATA: if (S_AXI_RREADY) rd_state_next = RD_IDLE;
    endcase
  end

  // Read FSM state register.
  always_ff @(posedge M_AXI_ACLK) begin
    if (!RESETN) rd_state <= RD_IDLE;
    else         rd_state <= rd_state_next;
  end

  // Read channel flops: sample the bank (pre-write value) on the AR handshake.
  always_ff @(posedge M_AXI_ACLK) begin
    if (!RESETN) begin
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RDATA   <= '0;
      S_AXI_RRESP   <= RESP_OKAY;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          if (ar_hs) begin
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RDATA   <= rd_ok ? regs[rd_idx[IDX_W-1:0]] : '0;
            S_AXI_RRESP   <= rd_ok ? RESP_OKAY : RESP_SLVERR;
          end else begin
            S_AXI_ARREADY <= 1'b1;
          end
        end
        RD_DATA: if (S_AXI_RREADY) S_AXI_ARREADY <= 1'b1;
      endcase
    end
  end

  assign S_AXI_RVALID = (rd_state == RD_DATA);

  // Flatten the bank for user logic.
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
    assign REGS_OUT[32*g +: 32] = regs[g];
  end

endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// Self-checking bench for axi4_lite_slave_regs: a table of single write/read
// transactions followed by hand-written multi-cycle handshake sequences.
module tb_axi4_lite_slave_regs;

  localparam int NR = 16;

  logic              clk = 1'b0;
  logic              resetn;
  logic [31:0]       awaddr, wdata, araddr, rdata;
  logic [2:0]        awprot, arprot;
  logic [3:0]        wstrb;
  logic              awvalid, awready, wvalid, wready, bvalid, bready;
  logic              arvalid, arready, rvalid, rready;
  logic [1:0]        bresp, rresp;
  logic [32*NR-1:0]  regs_out;
  logic              wr_pulse;
  logic [7:0]        wr_index;

  always #5 clk = ~clk;

  axi4_lite_slave_regs #(.C_AXI_DATA_WIDTH(32), .C_AXI_ADDR_WIDTH(32), .NUM_REGS(NR)) dut (
    .M_AXI_ACLK(clk), .RESETN(resetn),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .REGS_OUT(regs_out), .WR_PULSE(wr_pulse), .WR_INDEX(wr_index)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Notify-pulse monitor: counts high cycles, remembers the last index.
  int         pulse_cycles = 0;
  logic [7:0] last_index   = '0;
  always @(negedge clk) begin
    if (wr_pulse === 1'b1) begin
      pulse_cycles++;
      last_index = wr_index;
    end
  end

  logic [31:0] model [NR];

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] exp;   // write: new register value; read: expected RDATA
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [32*NR-1:0] flat_model();
    logic [32*NR-1:0] r;
    for (int i = 0; i < NR; i++) r[32*i +: 32] = model[i];
    return r;
  endfunction

  // AW and W offered together, BREADY high; reports BVALID/BRESP after the accepting edge.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          output logic [1:0] resp, output logic bv, output logic ok);
    logic aw_r, w_r;
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    ok = 1'b0; bv = 1'b0; resp = 2'b11;
    for (int c = 0; c < 20 && (awvalid || wvalid); c++) begin
      aw_r = awready; w_r = wready;
      tick();
      if (aw_r) awvalid = 1'b0;
      if (w_r)  wvalid  = 1'b0;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    if (!(aw_r && w_r) && (awready === 1'b0) && (wready === 1'b0) && bvalid === 1'b0) ok = 1'b0;
    bv   = bvalid;
    resp = bresp;
    ok   = (bv === 1'b1);
    tick();
    bready = 1'b0;
  endtask

  // AR offered with RREADY high; reports RDATA/RRESP after the accepting edge.
  task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp,
                         output logic ok);
    logic ar_r;
    araddr = addr; arvalid = 1'b1; rready = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 20 && arvalid; c++) begin
      ar_r = arready;
      tick();
      if (ar_r) arvalid = 1'b0;
    end
    arvalid = 1'b0;
    ok   = (rvalid === 1'b1);
    data = rdata;
    resp = rresp;
    tick();
    rready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  resp;
    logic [31:0] data;
    logic        bv, ok;
    int          p0, idx;

    vecs[0]  = '{1'b1, 32'h08,  32'h12345678, 4'hF, 2'b00, 32'h12345678};
    vecs[1]  = '{1'b1, 32'h0C,  32'hCAFEF00D, 4'hF, 2'b00, 32'hCAFEF00D};
    vecs[2]  = '{1'b1, 32'h0E,  32'h11223344, 4'h8, 2'b00, 32'h11FEF00D};
    vecs[3]  = '{1'b1, 32'h40,  32'hDEADBEEF, 4'hF, 2'b10, 32'h00000000};
    vecs[4]  = '{1'b1, 32'h3C,  32'hFFFFFFFF, 4'h3, 2'b00, 32'h0000FFFF};
    vecs[5]  = '{1'b0, 32'h08,  32'h0,        4'h0, 2'b00, 32'h12345678};
    vecs[6]  = '{1'b0, 32'h0C,  32'h0,        4'h0, 2'b00, 32'h11FEF00D};
    vecs[7]  = '{1'b0, 32'h40,  32'h0,        4'h0, 2'b10, 32'h00000000};
    vecs[8]  = '{1'b0, 32'h3C,  32'h0,        4'h0, 2'b00, 32'h0000FFFF};
    vecs[9]  = '{1'b0, 32'h3FC, 32'h0,        4'h0, 2'b10, 32'h00000000};
    vecs[10] = '{1'b0, 32'h00,  32'h0,        4'h0, 2'b00, 32'h00000000};
    for (int i = 0; i < NR; i++) model[i] = '0;

    resetn = 1'b0; awprot = '0; arprot = '0;
    awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;

    // Reset state.
    tick(); tick();
    check("rst_awready", awready, 0);
    check("rst_wready", wready, 0);
    check("rst_arready", arready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_regs_zero", 32'(regs_out === '0), 1);
    check("rst_wr_pulse", wr_pulse, 0);
    check("rst_wr_index", wr_index, 0);
    check("rst_rdata", rdata, 0);
    resetn = 1'b1;
    tick();
    check("post_rst_awready", awready, 1);
    check("post_rst_wready", wready, 1);
    check("post_rst_arready", arready, 1);

    // Table-driven single transactions.
    for (int i = 0; i < 11; i++) begin
      idx = int'(vecs[i].addr[9:2]);
      if (vecs[i].wr) begin
        p0 = pulse_cycles;
        do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp, bv, ok);
        check($sformatf("v%0d_bvalid", i), bv, 1);
        check($sformatf("v%0d_bresp", i), resp, vecs[i].resp);
        if (idx < NR) begin
          model[idx] = vecs[i].exp;
          check($sformatf("v%0d_pulse_cycles", i), pulse_cycles - p0, 1);
          check($sformatf("v%0d_wr_index", i), last_index, idx);
        end else begin
          check($sformatf("v%0d_no_pulse", i), pulse_cycles - p0, 0);
        end
        check($sformatf("v%0d_regs_out", i), 32'(regs_out === flat_model()), 1);
      end else begin
        do_read(vecs[i].addr, data, resp, ok);
        check($sformatf("v%0d_rvalid", i), ok, 1);
        check($sformatf("v%0d_rdata", i), data, vecs[i].exp);
        check($sformatf("v%0d_rresp", i), resp, vecs[i].resp);
      end
    end

    // AW three cycles ahead of W, partial strobe on reg1.
    awaddr = 32'h04; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("aw_first_awready_low", awready, 0);
      check("aw_first_no_bvalid", bvalid, 0);
      if (c < 2) tick();
    end
    wdata = 32'hAABBCCDD; wstrb = 4'b0101; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    check("aw_first_bvalid", bvalid, 1);
    check("aw_first_bresp", bresp, 0);
    check("aw_first_reg1", regs_out[63:32], 32'h00BB00DD);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check("aw_first_bvalid_drop", bvalid, 0);
    tick();
    check("aw_first_single_bvalid", bvalid, 0);

    // W ahead of AW, BREADY held low for 5 cycles.
    awaddr = 32'h10; wdata = 32'h55AA55AA; wstrb = 4'hF;
    wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    check("w_first_wready_low", wready, 0);
    check("w_first_awready_high", awready, 1);
    awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    check("w_first_reg4", regs_out[159:128], 32'h55AA55AA);
    for (int c = 0; c < 5; c++) begin
      check("stall_bvalid", bvalid, 1);
      check("stall_bresp", bresp, 0);
      check("stall_awready", awready, 0);
      check("stall_wready", wready, 0);
      tick();
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check("b_hs_bvalid", bvalid, 0);
    check("b_hs_awready", awready, 1);
    check("b_hs_wready", wready, 1);

    // Read reg2 with RREADY delayed; a second AR waits for the R handshake.
    araddr = 32'h08; arvalid = 1'b1; rready = 1'b0;
    tick();
    check("rd_stall_rvalid0", rvalid, 1);
    check("rd_stall_rdata0", rdata, 32'h12345678);
    check("rd_stall_rresp0", rresp, 0);
    araddr = 32'h10;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("rd_stall_rvalid", rvalid, 1);
      check("rd_stall_rdata", rdata, 32'h12345678);
      check("rd_stall_arready", arready, 0);
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    check("r_hs_rvalid", rvalid, 0);
    check("r_hs_arready", arready, 1);
    tick();
    arvalid = 1'b0;
    check("rd_second_rvalid", rvalid, 1);
    check("rd_second_rdata", rdata, 32'h55AA55AA);
    rready = 1'b1;
    tick();
    rready = 1'b0;

    // Same-cycle read and write of reg2: read sees the old value.
    awaddr = 32'h08; wdata = 32'h87654321; wstrb = 4'hF; araddr = 32'h08;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    check("rw_same_rdata_old", rdata, 32'h12345678);
    check("rw_same_reg2_new", regs_out[95:64], 32'h87654321);
    check("rw_same_bvalid", bvalid, 1);
    check("rw_same_rvalid", rvalid, 1);

    // Reset while both responses are pending.
    resetn = 1'b0;
    tick();
    check("mid_rst_bvalid", bvalid, 0);
    check("mid_rst_rvalid", rvalid, 0);
    check("mid_rst_regs_zero", 32'(regs_out === '0), 1);
    check("mid_rst_awready", awready, 0);
    check("mid_rst_arready", arready, 0);
    resetn = 1'b1;
    tick();
    check("mid_rel_awready", awready, 1);
    check("mid_rel_wready", wready, 1);
    check("mid_rel_arready", arready, 1);
    tick();
    check("mid_rel_no_bvalid", bvalid, 0);
    check("mid_rel_no_rvalid", rvalid, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
